// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract on one shared full-adder cell; done pulses WIDTH edges after the start edge.
// No backpressure: start is only sampled in IDLE and is dropped (never queued) while busy or done.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res_q;
    logic             carry;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    serial_adder_fa u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 rides in on the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res_q <= '0;
            carry <= 1'b0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res_q <= {fa_sum, res_q[WIDTH-1:1]};
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_cout;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        ovf_q <= carry ^ fa_cout;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = res_q;
    assign cout   = carry;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: arithmetic reference model plus directed literal cases and random traffic.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: age = edges since the accepted start (-1 when idle).
    int           age = -1;
    logic [W-1:0] p_res, m_res;
    logic         p_cout, m_cout;
    logic         p_ovf, m_ovf;

    function automatic int sval(input logic [W-1:0] v);
        int u;
        u = int'(v);
        return (u >= (1 << (W - 1))) ? u - (1 << W) : u;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age    = -1;
            m_res  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (age == -1) begin
            if (start) begin
                int ua, ub, sr;
                ua = int'(a);
                ub = int'(b);
                if (sub) begin
                    p_res  = W'(ua - ub);
                    p_cout = (ua >= ub);
                    sr     = sval(a) - sval(b);
                end else begin
                    p_res  = W'(ua + ub);
                    p_cout = ((ua + ub) >= (1 << W));
                    sr     = sval(a) + sval(b);
                end
                p_ovf = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
                age   = 0;
            end
        end else if (age == W) begin
            age = -1;
        end else begin
            age++;
            if (age == W) begin
                m_res  = p_res;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(age >= 0 && age < W));
        chk("done", 32'(done), 32'(age == W));
        if (age == -1 || age == W) begin
            chk("model_result", 32'(result), 32'(m_res));
            chk("model_cout", 32'(cout), 32'(m_cout));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    // One operation with literal expectations; returns at the done cycle + 1.
    task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic [W-1:0] er, input logic ec,
                         input logic eo, input logic chk_c);
        int n;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(W));
        chk({nm, "_result"}, 32'(result), 32'(er));
        if (chk_c) chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        chk({nm, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] rsv;
        int q[$];

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_op("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op("sub_nb",    8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
        do_op("sub_brw",   8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        do_op("ovf_add",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        do_op("ovf_sub",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // start pulsed three cycles into RUN with different operands
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h99; b = 8'h11; sub = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h5A; b = 8'hC3;
        ndone = 0;
        rsv = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                rsv = result;
            end
        end
        chk("busy_start_dones", 32'(ndone), 32'd1);
        chk("busy_start_result", 32'(rsv), 32'h46);
        chk("busy_start_hold", 32'(result), 32'h46);

        // asynchronous reset four cycles into RUN
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_result_hold", 32'(result), 32'd0);
        do_op("post_rst", 8'h10, 8'h22, 1'b0, 8'h32, 1'b0, 1'b0, 1'b1);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1; a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (done) q.push_back(cyc);
            a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
        end
        start = 1'b0;
        chk("b2b_count", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            chk("b2b_gap1", 32'(q[1] - q[0]), 32'd10);
            chk("b2b_gap2", 32'(q[2] - q[1]), 32'd10);
        end
        repeat (12) @(negedge clk);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = $urandom;
            b = $urandom;
            sub = $urandom_range(0, 1);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
